sodor_scratchpad_mem: RTL
=========================

SODOR_SCRATCHPAD_MEM -- requirements
Module: sodor_scratchpad_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 65536, number of 32-bit words (256 KiB).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h80000000, byte address of word 0.
REQ-003 SHALL have port clock, input, 1, the single clock; all state SHALL be rising-edge.
REQ-004 SHALL have port reset, input, 1; asynchronous, active-high.
REQ-005 SHALL have port io_req_valid, input, 1, request present this cycle.
REQ-006 SHALL have port io_req_bits_addr, input, 32, byte address.
REQ-007 SHALL have port io_req_bits_data, input, 32, store data, right-aligned.
REQ-008 SHALL have port io_req_bits_fcn, input, 1, 0 = read (M_XRD), 1 = write (M_XWR).
REQ-009 SHALL have port io_req_bits_typ, input, 3: 1 = B, 2 = H, 5 = BU, 6 = HU; 0/3/4/7 = word.
REQ-010 SHALL have port io_resp_valid, output, 1, response strobe.
REQ-011 SHALL have port io_resp_bits_data, output, 32, formatted load data.
REQ-012 SHALL have port io_resp_addr, output, 32, address of the request being answered; drives the router's io_respAddress.
REQ-013 SHALL have port io_misaligned, output, 1, misalignment flag, qualified by io_resp_valid.

Function
REQ-014 SHALL accept a request every cycle io_req_valid = 1; no backpressure, no ready signal.
REQ-015 SHALL assert io_resp_valid exactly one cycle after each accepted request, reads and writes alike; back-to-back requests give back-to-back responses.
REQ-016 SHALL hold io_resp_addr and io_resp_bits_data stable from one response until the next response or reset.
REQ-017 SHALL be in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS; word index = (addr - BASE_ADDR) >> 2.
REQ-018 SHALL read through a synchronous array: index registered in the request cycle, data selected in the response cycle.
REQ-019 SHALL format load data by registered typ and addr[1:0]:
  - B/BU: byte lane addr[1:0], sign- or zero-extended.
  - H/HU: half lane addr[1], sign- or zero-extended.
  - word: unchanged.
REQ-020 SHALL commit writes at the rising edge ending the request cycle, using byte enables:
  - B: data[7:0] to lane addr[1:0].
  - H: data[15:0] to lane addr[1].
  - word: all four lanes.
REQ-021 SHALL return data 32'h0 on a write response.
REQ-022 SHALL return the newly written value for a read to the same word in the cycle after a write; the write completes first.
REQ-023 SHALL handle out-of-range requests as follows: write discarded, read returns 32'h0, io_resp_valid still asserted.
REQ-024 SHALL support typ BU/HU only on reads; a write with typ BU/HU SHALL be treated as B/H.
REQ-025 SHALL NOT update the response registers while io_req_valid = 0 (io_resp_valid = 0 on the next cycle).

Reset
REQ-026 SHALL force io_resp_valid = 0, io_resp_bits_data = 0, io_resp_addr = 0 and io_misaligned = 0 immediately on reset assertion.
REQ-027 SHALL drop any pending response while reset is asserted and SHALL NOT commit a write on an edge where reset is asserted.
REQ-028 SHALL NOT reset array contents.

Configuration
REQ-029 SHALL implement macro SODOR_SCRATCH_MISALIGN_CHECK_EN:
  - Defined: H/HU with addr[0] = 1, or word with addr[1:0] != 0, SHALL suppress the write, return data 32'h0, and assert io_misaligned with the response.
  - Undefined: low address bits SHALL be ignored for alignment (H aligns to addr[1], word to addr[1:0] = 0), and io_misaligned SHALL be constant 0.

Verification
REQ-030 SHALL cover: word write 0xDEADBEEF @0x80000010, then read word @0x80000010 next cycle -> resp data 0xDEADBEEF, resp_addr 0x80000010, one cycle after the read.
REQ-031 SHALL cover: after REQ-030, read B @0x80000013 -> 0xFFFFFFDE; BU -> 0x000000DE; HU @0x80000012 -> 0x0000DEAD.
REQ-032 SHALL cover: byte write 0x12345677 @0x80000011 over 0xDEADBEEF, then word read -> 0xDEAD77EF.
REQ-033 SHALL cover: write @0x00001000, then read @0x00001000 -> both responses valid, read data 0, array unchanged.
REQ-034 SHALL cover: with macro defined, word write @0x80000002 -> io_misaligned = 1, memory unchanged; with macro undefined -> write lands at 0x80000000, io_misaligned = 0.
REQ-035 SHALL cover: 8 back-to-back reads with reset asserted mid-stream -> io_resp_valid drops the same cycle, no response for the request in the reset cycle, and streaming resumes one cycle after release.

Source files
------------

// File: rtl/sodor_scratchpad_mem.sv
// sodor_scratchpad_mem: single-port scratchpad with one-cycle responses, byte/half/word access.
// Optional build macro SODOR_SCRATCH_MISALIGN_CHECK_EN flags and suppresses misaligned H/W accesses.
module sodor_scratchpad_mem #(
    parameter int unsigned DEPTH_WORDS = 65536,
    parameter logic [31:0] BASE_ADDR   = 32'h80000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_valid,
    input  logic [31:0] io_req_bits_addr,
    input  logic [31:0] io_req_bits_data,
    input  logic        io_req_bits_fcn,
    input  logic [2:0]  io_req_bits_typ,
    output logic        io_resp_valid,
    output logic [31:0] io_resp_bits_data,
    output logic [31:0] io_resp_addr,
    output logic        io_misaligned
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 2;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] offset, wdata, rd_word, fmt, addr_q, hold_q;
    logic [AW-1:0] idx, idx_q;
    logic [3:0] be;
    logic [2:0] typ_q;
    logic [7:0] b8;
    logic [15:0] h16;
    logic in_range, is_b, is_h, mis, acc_wr, valid_q, rd_ok_q, mis_q;

    assign offset   = io_req_bits_addr - BASE_ADDR;
    assign in_range = io_req_bits_addr >= BASE_ADDR && {32'h0, offset} < SPAN;
    assign idx      = offset[AW+1:2];
    // typ 1/5 are bytes and 2/6 are halves; everything else is a full word
    assign is_b     = io_req_bits_typ[1:0] == 2'b01;
    assign is_h     = io_req_bits_typ[1:0] == 2'b10;
`ifdef SODOR_SCRATCH_MISALIGN_CHECK_EN
    assign mis      = is_h ? io_req_bits_addr[0] : !is_b && io_req_bits_addr[1:0] != 2'b00;
`else
    assign mis      = 1'b0;
`endif
    assign be       = is_b ? 4'b0001 << io_req_bits_addr[1:0] : is_h ? (io_req_bits_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata    = is_b ? {4{io_req_bits_data[7:0]}} : is_h ? {2{io_req_bits_data[15:0]}} : io_req_bits_data;
    assign acc_wr   = io_req_valid && io_req_bits_fcn && in_range && !mis;

    // Byte-enabled store at the edge ending the request cycle; contents survive reset
    always_ff @(posedge clock) begin
        if (!reset && acc_wr)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    // Capture request attributes; hold last response data across idle cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            rd_ok_q <= 1'b0;
            mis_q   <= 1'b0;
            typ_q   <= 3'd0;
            idx_q   <= '0;
            addr_q  <= 32'h0;
            hold_q  <= 32'h0;
        end else begin
            valid_q <= io_req_valid;
            if (valid_q) hold_q <= io_resp_bits_data;
            if (io_req_valid) begin
                rd_ok_q <= !io_req_bits_fcn && in_range && !mis;
                mis_q   <= mis;
                typ_q   <= io_req_bits_typ;
                idx_q   <= idx;
                addr_q  <= io_req_bits_addr;
            end
        end
    end

    assign rd_word = mem[idx_q];
    assign b8      = rd_word[{addr_q[1:0], 3'b000} +: 8];
    assign h16     = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    assign fmt     = typ_q[1:0] == 2'b01 ? {{24{!typ_q[2] && b8[7]}}, b8}
                   : typ_q[1:0] == 2'b10 ? {{16{!typ_q[2] && h16[15]}}, h16} : rd_word;

    assign io_resp_valid     = valid_q;
    assign io_resp_bits_data = valid_q ? (rd_ok_q ? fmt : 32'h0) : hold_q;
    assign io_resp_addr      = addr_q;
    assign io_misaligned     = mis_q;
endmodule
